// File: rtl/end_screen_fade_seq.sv
// End-screen fade sequencer: frame-counted fade-in, hold at full brightness, fade-out,
// scaling the palette RGB for each sprite pixel by the current fade level.
module end_screen_fade_seq #(
    parameter int FRAMES_PER_STEP = 2,
    parameter int HOLD_FRAMES     = 120
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic       skip_i,
    input  logic       vsync_i,
    input  logic       pix_valid_i,
    input  logic [3:0] pix_index_i,
    output logic [3:0] pal_index_o,
    input  logic [3:0] pal_red_i,
    input  logic [3:0] pal_green_i,
    input  logic [3:0] pal_blue_i,
    output logic [3:0] out_red_o,
    output logic [3:0] out_green_o,
    output logic [3:0] out_blue_o,
    output logic       out_valid_o,
    output logic [3:0] level_o,
    output logic       active_o,
    output logic       done_o
);

    localparam int FRAME_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam int HOLD_W  = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAMES_PER_STEP - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_FRAMES - 1);

    typedef enum logic [2:0] {
        IDLE,
        FADE_IN,
        HOLD,
        FADE_OUT,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         level_q, level_d;
    logic [FRAME_W-1:0] frameCnt_q, frameCnt_d;
    logic [HOLD_W-1:0]  holdCnt_q, holdCnt_d;
    logic               vsync_q;
    logic               frameTick;

    logic [3:0] fadedRed, fadedGreen, fadedBlue;
    logic [3:0] outRed_q, outGreen_q, outBlue_q;
    logic       outValid_q;

    assign frameTick = vsync_q & ~vsync_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            level_q    <= 4'd0;
            frameCnt_q <= '0;
            holdCnt_q  <= '0;
            vsync_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            frameCnt_q <= frameCnt_d;
            holdCnt_q  <= holdCnt_d;
            vsync_q    <= vsync_i;
        end
    end

    // A skip in FADE_IN/HOLD wins over a coincident frame tick, which is then discarded.
    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        frameCnt_d = frameCnt_q;
        holdCnt_d  = holdCnt_q;
        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d    = FADE_IN;
                    level_d    = 4'd0;
                    frameCnt_d = '0;
                    holdCnt_d  = '0;
                end
            end
            FADE_IN: begin
                if (skip_i) begin
                    state_d    = HOLD;
                    level_d    = 4'd15;
                    frameCnt_d = '0;
                    holdCnt_d  = '0;
                end else if (frameTick) begin
                    if (frameCnt_q == FRAME_LAST) begin
                        frameCnt_d = '0;
                        level_d    = level_q + 4'd1;
                        if (level_q == 4'd14) begin
                            state_d   = HOLD;
                            holdCnt_d = '0;
                        end
                    end else begin
                        frameCnt_d = frameCnt_q + FRAME_W'(1);
                    end
                end
            end
            HOLD: begin
                level_d = 4'd15;
                if (skip_i) begin
                    state_d    = FADE_OUT;
                    frameCnt_d = '0;
                    holdCnt_d  = '0;
                end else if (frameTick) begin
                    if (holdCnt_q == HOLD_LAST) begin
                        state_d    = FADE_OUT;
                        frameCnt_d = '0;
                        holdCnt_d  = '0;
                    end else begin
                        holdCnt_d = holdCnt_q + HOLD_W'(1);
                    end
                end
            end
            FADE_OUT: begin
                if (frameTick) begin
                    if (frameCnt_q == FRAME_LAST) begin
                        frameCnt_d = '0;
                        level_d    = level_q - 4'd1;
                        if (level_q == 4'd1) begin
                            state_d = DONE;
                        end
                    end else begin
                        frameCnt_d = frameCnt_q + FRAME_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Level 15 multiplies by 16 so the top nibble returns the palette colour unchanged.
    function automatic logic [3:0] scaleChannel(input logic [3:0] colour, input logic [3:0] lvl);
        logic [7:0] product;
        product = {4'b0000, colour} * ({4'b0000, lvl} + 8'd1);
        return (lvl == 4'd0) ? 4'd0 : product[7:4];
    endfunction

    assign pal_index_o = pix_index_i;
    assign fadedRed    = scaleChannel(pal_red_i, level_q);
    assign fadedGreen  = scaleChannel(pal_green_i, level_q);
    assign fadedBlue   = scaleChannel(pal_blue_i, level_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outRed_q   <= 4'd0;
            outGreen_q <= 4'd0;
            outBlue_q  <= 4'd0;
            outValid_q <= 1'b0;
        end else begin
            outRed_q   <= pix_valid_i ? fadedRed   : 4'd0;
            outGreen_q <= pix_valid_i ? fadedGreen : 4'd0;
            outBlue_q  <= pix_valid_i ? fadedBlue  : 4'd0;
            outValid_q <= pix_valid_i;
        end
    end

    assign out_red_o   = outRed_q;
    assign out_green_o = outGreen_q;
    assign out_blue_o  = outBlue_q;
    assign out_valid_o = outValid_q;
    assign level_o     = level_q;
    assign active_o    = (state_q == FADE_IN) || (state_q == HOLD) || (state_q == FADE_OUT);
    assign done_o      = (state_q == DONE);

endmodule
